// File: rtl/boot_loader_pkg.sv
// Shared state encodings, header field sizes and address helper for the boot loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      ST_ADDR  = 3'd0,
      ST_COUNT = 3'd1,
      ST_DATA  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

   localparam int ADDR_BYTES        = 8;
   localparam int COUNT_BYTES       = 4;
   localparam int WORD_BYTES        = 4;
   localparam int DEFAULT_MAX_WORDS = 1024;

   // Byte address of word idx relative to base; wraps modulo 2^64.
   function automatic logic [63:0] word_addr(input logic [63:0] base, input logic [31:0] idx);
      return base + {30'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/bl_byte_assembler.sv
// Shifts stream bytes into a 64-bit little-endian register and flags 4/8-byte field completion.
// Latency: completion flags and shift_nxt are combinational on the accepted byte.
// Backpressure: none of its own; byte_vld must already be qualified by the handshake.
module bl_byte_assembler
   import boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   input  logic        wide,
   output logic [63:0] shift_nxt,
   output logic        done4,
   output logic        done8
);

   logic [63:0] shift_q, shift_d;
   logic [2:0]  cnt_q, cnt_d;

   // Newest byte enters at the top so the first byte of an 8-byte field ends at [7:0]
   // and the first byte of a 4-byte field ends at [39:32].
   always_comb begin
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      shift_nxt = {byte_dat, shift_q[63:8]};
      done4     = byte_vld && !wide && (cnt_q == 3'(COUNT_BYTES - 1));
      done8     = byte_vld &&  wide && (cnt_q == 3'(ADDR_BYTES - 1));
      if (byte_vld) begin
         shift_d = shift_nxt;
         cnt_d   = (done4 || done8) ? 3'd0 : cnt_q + 3'd1;
      end
   end

   // Shift register and byte counter; reset abandons any partially gathered field.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Parses an addr/count/payload/checksum byte frame and writes the payload into instruction memory.
// Latency: one wr_en pulse the cycle after each word's 4th byte; done/error the cycle after the checksum.
// Backpressure: in_ready high while parsing, low once terminal; bytes offered in DONE/ERROR are dropped.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int          MAX_WORDS = DEFAULT_MAX_WORDS,
   parameter logic [63:0] IMEM_BASE = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [63:0] wr_addr,
   output logic [31:0] wr_data,
   output logic [63:0] init_pc,
   output logic        cpu_reset,
   output logic        done,
   output logic        error
);

   state_t      state_q, state_d;
   logic [63:0] load_addr_q, load_addr_d;
   logic [31:0] n_q, n_d;
   logic [31:0] idx_q, idx_d;
   logic [7:0]  csum_q, csum_d;
   logic        in_ready_q, in_ready_d;
   logic        wr_en_q, wr_en_d;
   logic [63:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [63:0] init_pc_q, init_pc_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic        done_q, done_d;
   logic        error_q, error_d;

   logic        take;
   logic        asm_vld;
   logic        asm_wide;
   logic [63:0] asm_val;
   logic        asm_done4;
   logic        asm_done8;
   logic [64:0] base_diff;
   logic        below_base;
   logic [31:0] n_field;

   assign take     = in_valid && in_ready_q;
   assign asm_vld  = take && (state_q == ST_ADDR || state_q == ST_COUNT || state_q == ST_DATA);
   assign asm_wide = (state_q == ST_ADDR);

   bl_byte_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .byte_vld  (asm_vld),
      .byte_dat  (in_data),
      .wide      (asm_wide),
      .shift_nxt (asm_val),
      .done4     (asm_done4),
      .done8     (asm_done8)
   );

   // Borrow out of a 65-bit subtract gives an unsigned address < IMEM_BASE test.
   assign base_diff  = {1'b0, asm_val} - {1'b0, IMEM_BASE};
   assign below_base = base_diff[64];
   assign n_field    = asm_val[63:32];

   // Frame parser: next state, field capture, word writes and registered status outputs.
   always_comb begin
      state_d     = state_q;
      load_addr_d = load_addr_q;
      n_d         = n_q;
      idx_d       = idx_q;
      csum_d      = csum_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      case (state_q)
         ST_ADDR: begin
            if (asm_done8) begin
               load_addr_d = asm_val;
               if (asm_val[1:0] != 2'b00 || below_base) state_d = ST_ERROR;
               else                                     state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (asm_done4) begin
               n_d   = n_field;
               idx_d = '0;
               if (n_field > 32'(MAX_WORDS)) state_d = ST_ERROR;
               else if (n_field == 32'd0)    state_d = ST_CHECK;
               else                          state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (take) csum_d = csum_q ^ in_data;
            if (asm_done4) begin
               wr_en_d   = 1'b1;
               wr_addr_d = word_addr(load_addr_q, idx_q);
               wr_data_d = asm_val[63:32];
               idx_d     = idx_q + 32'd1;
               if (idx_q + 32'd1 == n_q) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (take) state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
         end
         default: begin
         end
      endcase

      in_ready_d  = (state_d == ST_ADDR) || (state_d == ST_COUNT) ||
                    (state_d == ST_DATA) || (state_d == ST_CHECK);
      done_d      = (state_d == ST_DONE);
      error_d     = (state_d == ST_ERROR);
      cpu_reset_d = (state_d != ST_DONE);
      init_pc_d   = (state_d == ST_DONE) ? load_addr_q : 64'h0;
   end

   // State and output registers; reset drops any partial frame and restarts at the address field.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_ADDR;
         load_addr_q <= '0;
         n_q         <= '0;
         idx_q       <= '0;
         csum_q      <= '0;
         in_ready_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         init_pc_q   <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_addr_q <= load_addr_d;
         n_q         <= n_d;
         idx_q       <= idx_d;
         csum_q      <= csum_d;
         in_ready_q  <= in_ready_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         init_pc_q   <= init_pc_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign init_pc   = init_pc_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: directed frames push expected writes/results, a monitor checks them.
// Latency: n/a.
// Backpressure: bytes are only offered while in_ready is high.
module tb_boot_loader;

   localparam int MAXW = 1024;
   localparam int K_WR = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        wr_en;
   logic [63:0] wr_addr;
   logic [31:0] wr_data;
   logic [63:0] init_pc;
   logic        cpu_reset;
   logic        done;
   logic        error;

   typedef struct {
      int          kind;
      logic [63:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] pay[$];
   int          nvec = 0;
   int          nmis = 0;
   logic        done_p = 1'b0;
   logic        err_p = 1'b0;

   boot_loader #(.MAX_WORDS(MAXW), .IMEM_BASE(64'h0)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .init_pc   (init_pc),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      nvec++;
      if (act !== req) begin
         nmis++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   task automatic push_wr(input logic [63:0] a, input logic [31:0] d);
      exp_t e;
      e.kind = K_WR; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_res(input int k, input logic [63:0] pc);
      exp_t e;
      e.kind = k; e.addr = pc; e.data = 32'h0;
      exp_q.push_back(e);
   endtask

   // Called at a falling edge; returns at a falling edge.
   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gap) @(negedge clk);
      for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
      if (!in_ready) begin
         nvec++; nmis++;
         $display("FAIL in_ready_wait: in_ready=0 after 50 cycles, want 1");
         return;
      end
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic send_field(input logic [63:0] v, input int nb, input int maxgap);
      for (int i = 0; i < nb; i++) send_byte(v[8*i +: 8], maxgap);
   endtask

   task automatic send_payload(input int maxgap);
      foreach (pay[i]) send_field({32'h0, pay[i]}, 4, maxgap);
   endtask

   task automatic wait_drain(input string name);
      for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
      chk(name, 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
      chk("rst_wr_addr", wr_addr, 64'd0);
      chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
      chk("rst_init_pc", init_pc, 64'd0);
      chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_error", {63'd0, error}, 64'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
   endtask

   // Scoreboard monitor: pops one expectation per write pulse or per done/error rise.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               nvec++; nmis++;
               $display("FAIL unexpected_write: addr=%h data=%h, want no write", wr_addr, wr_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_kind", 64'(K_WR), 64'(mon_e.kind));
               chk("wr_addr", wr_addr, mon_e.addr);
               chk("wr_data", {32'd0, wr_data}, {32'd0, mon_e.data});
            end
         end
         if ((done && !done_p) || (error && !err_p)) begin
            if (exp_q.size() == 0) begin
               nvec++; nmis++;
               $display("FAIL unexpected_result: done=%b error=%b, want nothing", done, error);
            end else begin
               mon_e = exp_q.pop_front();
               chk("res_done", {63'd0, done}, (mon_e.kind == K_DONE) ? 64'd1 : 64'd0);
               chk("res_error", {63'd0, error}, (mon_e.kind == K_ERR) ? 64'd1 : 64'd0);
               chk("res_cpu_reset", {63'd0, cpu_reset}, (mon_e.kind == K_DONE) ? 64'd0 : 64'd1);
               chk("res_init_pc", init_pc, (mon_e.kind == K_DONE) ? mon_e.addr : 64'd0);
               chk("res_in_ready", {63'd0, in_ready}, 64'd0);
            end
         end
      end
      done_p = done;
      err_p  = error;
   end

   logic [7:0] cs;

   initial begin
      do_reset();

      // Two-word frame at 0; payload XOR is 13^20 = 0x33.
      pay = '{32'hD2800013, 32'hD2800020};
      push_wr(64'h0, 32'hD2800013);
      push_wr(64'h4, 32'hD2800020);
      push_res(K_DONE, 64'h0);
      send_field(64'h0, 8, 0);
      send_field(64'd2, 4, 0);
      send_payload(0);
      send_byte(8'h33, 0);
      wait_drain("frame_ok");

      // Same frame, wrong checksum: writes still happen, then error; later bytes are ignored.
      do_reset();
      push_wr(64'h0, 32'hD2800013);
      push_wr(64'h4, 32'hD2800020);
      push_res(K_ERR, 64'h0);
      send_field(64'h0, 8, 0);
      send_field(64'd2, 4, 0);
      send_payload(0);
      send_byte(8'h01, 0);
      wait_drain("frame_badsum");
      in_valid = 1'b1; in_data = 8'h33;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      chk("err_sticky_error", {63'd0, error}, 64'd1);
      chk("err_sticky_done", {63'd0, done}, 64'd0);
      chk("err_in_ready", {63'd0, in_ready}, 64'd0);

      // Misaligned load address: error right after the address field.
      do_reset();
      push_res(K_ERR, 64'h0);
      send_field(64'h1002, 8, 0);
      wait_drain("misaligned");

      // Count one above the limit.
      do_reset();
      push_res(K_ERR, 64'h0);
      send_field(64'h0, 8, 0);
      send_field(64'(MAXW + 1), 4, 0);
      wait_drain("count_over");

      // Empty image goes straight to the checksum byte.
      do_reset();
      push_res(K_DONE, 64'h200);
      send_field(64'h200, 8, 0);
      send_field(64'd0, 4, 0);
      send_byte(8'h00, 0);
      wait_drain("count_zero");

      // Original frame with random source gaps.
      do_reset();
      pay = '{32'hD2800013, 32'hD2800020};
      push_wr(64'h0, 32'hD2800013);
      push_wr(64'h4, 32'hD2800020);
      push_res(K_DONE, 64'h0);
      send_field(64'h0, 8, 5);
      send_field(64'd2, 4, 5);
      send_payload(5);
      send_byte(8'h33, 5);
      wait_drain("frame_gaps");

      // Write address wraps past 2^64; checksum 01^02^03^04 ^ A0^B0^C0^D0 ^ FF = 0xFB.
      do_reset();
      pay = '{32'h04030201, 32'hD0C0B0A0, 32'h000000FF};
      push_wr(64'hFFFF_FFFF_FFFF_FFF8, 32'h04030201);
      push_wr(64'hFFFF_FFFF_FFFF_FFFC, 32'hD0C0B0A0);
      push_wr(64'h0, 32'h000000FF);
      push_res(K_DONE, 64'hFFFF_FFFF_FFFF_FFF8);
      send_field(64'hFFFF_FFFF_FFFF_FFF8, 8, 0);
      send_field(64'd3, 4, 0);
      send_payload(0);
      send_byte(8'hFB, 0);
      wait_drain("addr_wrap");

      // Exactly MAX_WORDS words, word k = k; low and high bytes each cancel to 0x00.
      do_reset();
      pay.delete();
      cs = 8'h00;
      for (int k = 0; k < MAXW; k++) begin
         pay.push_back(32'(k));
         push_wr(64'h40 + 64'(4 * k), 32'(k));
         cs = cs ^ 8'(k) ^ 8'(k >> 8);
      end
      push_res(K_DONE, 64'h40);
      send_field(64'h40, 8, 0);
      send_field(64'(MAXW), 4, 0);
      send_payload(0);
      send_byte(8'h00, 0);
      wait_drain("count_max");

      // Reset after three payload bytes, then a fresh one-word frame at 0x100 (DE^AD^BE^EF = 0x22).
      do_reset();
      send_field(64'h0, 8, 0);
      send_field(64'd2, 4, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h80, 0);
      do_reset();
      pay = '{32'hDEADBEEF};
      push_wr(64'h100, 32'hDEADBEEF);
      push_res(K_DONE, 64'h100);
      send_field(64'h100, 8, 0);
      send_field(64'd1, 4, 0);
      send_payload(0);
      send_byte(8'h22, 0);
      wait_drain("mid_reset_reload");
      chk("final_done", {63'd0, done}, 64'd1);
      chk("final_init_pc", init_pc, 64'h100);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
